// File: rtl/approx_error_monitor.sv
// Sweeps all input vectors through an approximate |a-b| circuit and
// accumulates error statistics against the exact result.
module approx_error_monitor #(
  parameter int IN_W = 4,
  parameter int OUT_W = 2,
  parameter int ET = 1,
  localparam int HW = IN_W / 2,
  localparam int EW = (HW > OUT_W) ? HW : OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IN_W-1:0]   vec_o,
  output logic              vec_valid_o,
  input  logic [OUT_W-1:0]  approx_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [EW-1:0]     max_err,
  output logic [IN_W:0]     err_cnt,
  output logic [IN_W:0]     viol_cnt,
  output logic [EW+IN_W-1:0] sum_err
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  localparam logic [EW-1:0]   ET_W = EW'(ET);
  localparam logic [IN_W-1:0] LAST = IN_W'((1 << IN_W) - 1);

  state_t state, state_nx;
  logic [IN_W-1:0]  cnt;
  logic [IN_W-1:0]  s1_vec;
  logic [OUT_W-1:0] s1_approx;
  logic             s1_valid;
  logic             accept;

  logic [HW-1:0] a, b, exact;
  logic [EW-1:0] ex_w, ap_w, err, max_nx;

  assign accept      = (state == IDLE) && start;
  assign vec_valid_o = (state == SWEEP);
  assign vec_o       = vec_valid_o ? cnt : '0;
  assign busy        = (state == SWEEP) || (state == DRAIN);
  assign done        = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: fixed-length sweep, one drain cycle, one done cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = SWEEP;
      SWEEP: if (cnt == LAST) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Vector counter, restarted at every accepted start
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (accept)          cnt <= '0;
    else if (state == SWEEP)  cnt <= cnt + 1'b1;
  end

  // Stage 1: capture the vector and the circuit's combinational response
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vec    <= '0;
      s1_approx <= '0;
      s1_valid  <= 1'b0;
    end else begin
      s1_vec    <= vec_o;
      s1_approx <= approx_i;
      s1_valid  <= vec_valid_o;
    end
  end

  // Stage 2 arithmetic: both operands widened to EW before differencing
  always_comb begin
    a      = s1_vec[HW-1:0];
    b      = s1_vec[IN_W-1:HW];
    exact  = (a >= b) ? (a - b) : (b - a);
    ex_w   = EW'(exact);
    ap_w   = EW'(s1_approx);
    err    = (ex_w >= ap_w) ? (ex_w - ap_w) : (ap_w - ex_w);
    max_nx = (s1_valid && (err > max_err)) ? err : max_err;
  end

  // Stage 2 accumulators; the last vector lands on the DRAIN->DONE edge
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      max_err  <= '0;
      err_cnt  <= '0;
      viol_cnt <= '0;
      sum_err  <= '0;
    end else if (s1_valid) begin
      max_err  <= max_nx;
      err_cnt  <= err_cnt + (IN_W+1)'(err != '0);
      viol_cnt <= viol_cnt + (IN_W+1)'(err > ET_W);
      sum_err  <= sum_err + (EW+IN_W)'(err);
    end
  end

  // Verdict uses the final maximum so it is already valid while done is high
  always_ff @(posedge clk) begin
    if (rst || accept)       pass <= 1'b0;
    else if (state == DRAIN) pass <= (max_nx <= ET_W);
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Scoreboard bench for approx_error_monitor: models of the approximate
// circuit drive approx_i; expected statistics come from a plain sweep.
module tb_approx_error_monitor;

  localparam int IN_W = 4;
  localparam int OUT_W = 2;
  localparam int ET = 1;
  localparam int N = 1 << IN_W;

  typedef struct {
    int done_cyc;
    int maxe;
    int cnt;
    int viol;
    int sum;
    int pass;
  } exp_t;

  logic clk = 0;
  logic rst;
  logic start;
  logic [3:0] vec_o;
  logic vec_valid_o;
  logic [1:0] approx_i;
  logic busy, done, pass;
  logic [1:0] max_err;
  logic [4:0] err_cnt, viol_cnt;
  logic [5:0] sum_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ndone = 0;
  int mode = 0;
  int target = 0;
  int rnd [N];
  exp_t sb [$];

  approx_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_o(vec_o), .vec_valid_o(vec_valid_o), .approx_i(approx_i),
    .busy(busy), .done(done), .pass(pass),
    .max_err(max_err), .err_cnt(err_cnt),
    .viol_cnt(viol_cnt), .sum_err(sum_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int absdiff(int x, int y);
    return (x > y) ? x - y : y - x;
  endfunction

  function automatic int model(int m, int v);
    int ex, i0, i1, i2, i3;
    ex = absdiff(v % 4, v / 4);
    i0 = v & 1;
    i1 = (v >> 1) & 1;
    i2 = (v >> 2) & 1;
    i3 = (v >> 3) & 1;
    case (m)
      0: return ex;
      1: return 0;
      2: return ex ^ 1;
      3: return ((i0 & i2) | (~i0 & ~i2 & 1))
              + 2 * (((~i1 & 1) & i3) | (i0 & (~i2 & 1)));
      default: return rnd[v];
    endcase
  endfunction

  assign approx_i = 2'(model(mode, int'(vec_o)));

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t golden(int m, int dcyc);
    exp_t e;
    int er;
    e.done_cyc = dcyc;
    e.maxe = 0; e.cnt = 0; e.viol = 0; e.sum = 0;
    for (int v = 0; v < N; v++) begin
      er = absdiff(absdiff(v % 4, v / 4), model(m, v));
      if (er > e.maxe) e.maxe = er;
      if (er != 0) e.cnt++;
      if (er > ET) e.viol++;
      e.sum += er;
    end
    e.pass = (e.maxe <= ET) ? 1 : 0;
    return e;
  endfunction

  // Monitor: checks vector sequence and pops an expectation on each done
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (vec_valid_o && sb.size() > 0)
        chk("vec_seq", int'(vec_o),
            cyc - (sb[0].done_cyc - (N + 1)));
      if (done) begin
        ndone++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_at_done", int'(busy), 0);
          chk("max_err", int'(max_err), e.maxe);
          chk("err_cnt", int'(err_cnt), e.cnt);
          chk("viol_cnt", int'(viol_cnt), e.viol);
          chk("sum_err", int'(sum_err), e.sum);
          chk("pass", int'(pass), e.pass);
        end
      end
    end
  end

  task automatic issue(int m);
    mode = m;
    sb.push_back(golden(m, cyc + 1 + N + 1));
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(int t);
    int i;
    for (i = 0; i < 200 && ndone < t; i++) @(negedge clk);
    if (ndone < t) begin
      chk("timeout_done", ndone, t);
      sb.delete();
      ndone = t;
    end
  endtask

  task automatic fill_rnd();
    for (int v = 0; v < N; v++) rnd[v] = int'($urandom_range(0, 3));
  endtask

  initial begin
    int e2;
    rst = 1;
    start = 0;
    fill_rnd();
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_vv", int'(vec_valid_o), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rst = 0;
    @(negedge clk);

    for (int m = 0; m < 5; m++) begin
      issue(m);
      chk("busy_sweep", int'(busy), 1);
      wait_done(++target);
      @(negedge clk);
    end

    for (int r = 0; r < 3; r++) begin
      fill_rnd();
      issue(4);
      wait_done(++target);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    issue(3);
    repeat (5) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(++target);
    @(negedge clk);

    mode = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_vv", int'(vec_valid_o), 0);
    chk("mid_rst_vec", int'(vec_o), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_pass", int'(pass), 0);
    chk("mid_rst_max", int'(max_err), 0);
    chk("mid_rst_cnt", int'(err_cnt), 0);
    chk("mid_rst_viol", int'(viol_cnt), 0);
    chk("mid_rst_sum", int'(sum_err), 0);
    rst = 0;
    @(negedge clk);
    issue(1);
    wait_done(++target);
    @(negedge clk);

    mode = 3;
    e2 = cyc + 1 + N + 3;
    sb.push_back(golden(3, cyc + 1 + N + 1));
    sb.push_back(golden(3, e2 + N + 1));
    start = 1;
    for (int i = 0; i < 100 && cyc < e2; i++) @(negedge clk);
    start = 0;
    chk("b2b_accept_cyc", cyc, e2);
    chk("b2b_vec0", int'(vec_o), 0);
    chk("b2b_clr_cnt", int'(err_cnt), 0);
    chk("b2b_clr_sum", int'(sum_err), 0);
    chk("b2b_clr_pass", int'(pass), 0);
    target += 2;
    wait_done(target);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_error_monitor.md
# approx_error_monitor

Sequential error-evaluation stage that sits directly downstream of a generated approximate circuit, such as the 4-input/2-output SOP shared-logic abs_diff netlists. On a start pulse it sweeps every input vector into the approximate circuit and captures the circuit's combinational outputs. It compares each output against the exact |a − b| and accumulates error statistics. At the end of the sweep it reports pass/fail against the error threshold the netlist was synthesised for.

## Interface
Parameters:
- IN_W, 4, total approximate-circuit input bits (even); operand a = vec[IN_W/2-1:0], b = vec[IN_W-1:IN_W/2]
- OUT_W, 2, approximate-circuit output bits; approx value = sum of out_k·2^k
- ET, 1, error threshold (max tolerated absolute error)

Derived: N = 2^IN_W vectors; EW = max(IN_W/2, OUT_W) error width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  sweep request; honoured only in IDLE
- vec_o  out  IN_W  vector driven to approximate circuit in0..in(IN_W-1) (bit k → in k)
- vec_valid_o  out  1  high while vec_o carries a sweep vector
- approx_i  in  OUT_W  approximate circuit outputs (out0 = bit 0), combinational response to vec_o
- busy  out  1  sweep/drain in progress
- done  out  1  one-cycle pulse, results final
- pass  out  1  max_err ≤ ET, valid from done until next start
- max_err  out  EW  largest absolute error seen
- err_cnt  out  IN_W+1  vectors with error ≠ 0
- viol_cnt  out  IN_W+1  vectors with error > ET
- sum_err  out  EW+IN_W  sum of absolute errors

## Operation
- FSM: IDLE → SWEEP (N cycles) → DRAIN (1 cycle) → DONE (1 cycle) → IDLE.
- IDLE:
  - vec_o = 0, vec_valid_o = 0, busy = 0.
  - start = 1 moves the FSM to SWEEP and clears all result registers and pass on the same edge.
- SWEEP:
  - Internal counter drives vec_o = 0, 1, …, N−1, one per cycle; vec_valid_o = 1.
  - Wraps at N−1 into DRAIN; never re-presents vector 0.
- Pipeline stage 1 registers {vec_o, approx_i, vec_valid_o} at each edge.
- Stage 2 works from the stage-1 registers:
  - exact = |a − b| (unsigned, IN_W/2 bits)
  - err = |exact − approx| in EW bits, computed without overflow
  - If stage-1 valid, update: max_err = max(max_err, err); err_cnt += (err≠0); viol_cnt += (err>ET); sum_err += err.
- DRAIN: no new vector; stage 2 consumes the last vector.
- DONE: done = 1, pass = (max_err ≤ ET) registered; busy = 0.
- start outside IDLE is ignored; it does not restart the sweep or clear results.
- start held high continuously triggers back-to-back sweeps, each re-entering SWEEP from IDLE.
- Results and pass hold their values in IDLE until the next accepted start.
- Counters are sized so an all-error sweep does not saturate: err_cnt = N fits in IN_W+1 bits.

## Timing
- Let E0 be the edge accepting start.
  - Cycle k after E0 (k = 0..N−1): vec_o = k.
  - Stage 1 captures at E(k+1); accumulators update at E(k+2).
  - Cycle N is DRAIN; cycle N+1 is DONE with done high. FSM returns to IDLE at E(N+2).
- Start-to-done latency is N+1 cycles; busy is high in cycles 0..N.
- The approximate circuit is purely combinational; approx_i is sampled in the same cycle vec_o is driven. No extra wait state is allowed.
- rst (any state, including mid-sweep or DONE) takes effect at the next edge:
  - FSM = IDLE, counter = 0, pipeline valid = 0.
  - All results = 0; pass = 0, done = 0, busy = 0, vec_valid_o = 0, vec_o = 0.
- Reset has priority over start in the same cycle.

## Test plan
- approx_i driven by an exact model (IN_W=4, OUT_W=2) → after 18 cycles done=1, max_err=0, err_cnt=0, viol_cnt=0, sum_err=0, pass=1.
- approx_i tied to 0 → exact sum over 16 vectors: max_err=3, err_cnt=12, viol_cnt=6 (ET=1), sum_err=20, pass=0.
- approx_i = exact XOR 1 → max_err=1, err_cnt=16, viol_cnt=0, sum_err=16, pass=1 (threshold boundary err = ET).
- Bit-accurate model of the et1 SOP abs_diff netlist (out0 = in0·in2 | ~in0·~in2; out1 = ~in1·in3 | in0·~in2) → results equal the model's golden max_err/err_cnt/sum_err; vector 0 yields err=1.
- start pulsed at cycle 5 of a sweep → ignored, done still at cycle N+1. rst asserted at cycle 8 → all outputs zero next cycle; a fresh start then completes normally.
- start held high across DONE → second sweep begins immediately from IDLE; results cleared at the accepting edge; vec_o restarts at 0.
